coax_rx: RTL and testbench
==========================

COAX_RX -- requirements
Module: coax_rx

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BIT, default 8, meaning clocks per bit cell; even values >= 8 only.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx  input  1  asynchronous serial line from the coax receiver front end.
REQ-005 SHALL have port active  output  1  high while a frame is being received.
REQ-006 SHALL have port data  output  10  last received word; held until the next word.
REQ-007 SHALL have port strobe  output  1  one-cycle pulse: data and parity_error valid.
REQ-008 SHALL have port parity_error  output  1  parity mismatch flag for the word; valid with strobe.
REQ-009 SHALL have port error  output  1  one-cycle pulse: framing lost, frame aborted.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all decoding uses the synchronized level and a registered edge detect.
REQ-011 SHALL decode bits by mid-cell transition: falling edge = 1 (high then low), rising edge = 0 (low then high).
REQ-012 SHALL accept a mid-cell transition only within cell phase [CLOCKS_PER_BIT/4, 3*CLOCKS_PER_BIT/4]; transitions outside the window are cell-boundary edges and are ignored.
REQ-013 SHALL resynchronize the phase counter to CLOCKS_PER_BIT/2 on every accepted mid-cell transition.
REQ-014 SHALL implement states IDLE, QUIESCE, CV_HIGH, CV_LOW, SYNC, DATA, PARITY.
REQ-015 IDLE -> QUIESCE on the first decoded 1 bit; QUIESCE counts consecutive 1 bits; a decoded 0 resets the count.
REQ-016 QUIESCE -> CV_HIGH when the count is >= 5 and the line then stays high with no transition for more than 5/4*CLOCKS_PER_BIT clocks.
REQ-017 CV_HIGH -> CV_LOW on a falling edge with high width in [5/4, 7/4]*CLOCKS_PER_BIT; a width outside this range -> IDLE, no error.
REQ-018 CV_LOW -> SYNC on a rising edge with low width in [5/4, 7/4]*CLOCKS_PER_BIT; that edge sets cell phase 0 and asserts active on the next clock; otherwise -> IDLE, no error.
REQ-019 SYNC: decoded 1 -> DATA; decoded 0 is end of frame -> IDLE, active deasserted on the next clock, no error.
REQ-020 DATA SHALL shift in 10 bits MSB first, then -> PARITY.
REQ-021 PARITY: the received parity bit makes even parity over data plus parity; a mismatch sets parity_error.
REQ-022 After the parity bit, data and parity_error SHALL update and strobe SHALL pulse exactly one clock after the parity transition is detected; then -> SYNC.
REQ-023 A parity mismatch SHALL NOT abort the frame.
REQ-024 In SYNC, DATA or PARITY, no accepted transition by phase 3*CLOCKS_PER_BIT/4 + 1 SHALL pulse error for one clock, clear active, and go to IDLE without strobe.
REQ-025 Only one word per frame cycle SHALL be strobed; strobe and error SHALL never assert in the same clock.
REQ-026 Code-violation-shaped pulses seen outside QUIESCE SHALL be ignored.

Reset
REQ-027 Asserting reset SHALL immediately force state IDLE, active=0, data=0, strobe=0, parity_error=0, error=0, and clear all counters and synchronizer flops, including mid-frame.
REQ-028 After reset deasserts, the block SHALL require a complete quiesce plus code violation before decoding any word.

Verification (CLOCKS_PER_BIT=8)
REQ-029 Reset pulse with rx idle low -> all outputs 0, state IDLE, no strobe within 100 clocks.
REQ-030 Frame: 5 quiesce, code violation, sync 1, 10'b0101110101, parity 0, end sync 0 -> one strobe, data=10'b0101110101, parity_error=0, active low after the end bit.
REQ-031 Two words 10'b0101110101 (parity 0) then 10'b1010001110 (parity 1) in one frame -> two strobes in order with correct data, parity_error=0 on both.
REQ-032 Same frame with the parity bit inverted -> strobe with parity_error=1; the following word is still received.
REQ-033 rx held high for 2 cells during DATA -> single-cycle error, active=0, no strobe; the next valid frame decodes correctly.
REQ-034 Only 3 quiesce bits before the code violation -> no active, no strobe; reset asserted mid-word -> outputs 0 immediately.

Source files
------------

// File: rtl/coax_rx.sv
// Coax serial word receiver: mid-cell transition bit decoding, quiesce plus code-violation
// frame sync, then 10-bit words (MSB first) each followed by an even-parity bit.
module coax_rx #(
    parameter int CLOCKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       active,
    output logic [9:0] data,
    output logic       strobe,
    output logic       parity_error,
    output logic       error
);
    localparam int PW = $clog2(CLOCKS_PER_BIT);
    localparam int WW = $clog2(2 * CLOCKS_PER_BIT) + 1;

    localparam logic [PW-1:0] PH_LAST = PW'(CLOCKS_PER_BIT - 1);
    localparam logic [PW-1:0] PH_HALF = PW'(CLOCKS_PER_BIT / 2);
    localparam logic [PW-1:0] WIN_LO  = PW'(CLOCKS_PER_BIT / 4);
    localparam logic [PW-1:0] WIN_HI  = PW'(3 * CLOCKS_PER_BIT / 4);
    localparam logic [PW-1:0] PH_TMO  = PW'(3 * CLOCKS_PER_BIT / 4 + 1);
    localparam logic [WW-1:0] CV_MIN  = WW'(CLOCKS_PER_BIT + CLOCKS_PER_BIT / 4);
    localparam logic [WW-1:0] CV_MAX  = WW'(CLOCKS_PER_BIT + 3 * CLOCKS_PER_BIT / 4);
    localparam logic [WW-1:0] W_SAT   = WW'(2 * CLOCKS_PER_BIT);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_QUIESCE = 3'd1;
    localparam logic [2:0] S_CV_HIGH = 3'd2;
    localparam logic [2:0] S_CV_LOW  = 3'd3;
    localparam logic [2:0] S_SYNC    = 3'd4;
    localparam logic [2:0] S_DATA    = 3'd5;
    localparam logic [2:0] S_PARITY  = 3'd6;

    function automatic logic parity_mismatch(input logic [9:0] word, input logic pbit);
        return ^{word, pbit};
    endfunction

    logic          sync1_q, sync2_q, prev_q;
    logic [2:0]    state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          mid_seen_q, mid_seen_d;
    logic [WW-1:0] width_q, width_d;
    logic [2:0]    qcount_q, qcount_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [9:0]    data_q, data_d;
    logic          perr_q, perr_d;
    logic          strobe_q, strobe_d;
    logic          error_q, error_d;
    logic          active_q, active_d;

    logic edge_s, rise_s, fall_s, accept_s, in_cv_s;

    assign edge_s   = sync2_q ^ prev_q;
    assign rise_s   = sync2_q & ~prev_q;
    assign fall_s   = ~sync2_q & prev_q;
    // One mid-cell transition per cell; boundary edges land outside the window.
    assign accept_s = edge_s && !mid_seen_q && (phase_q >= WIN_LO) && (phase_q <= WIN_HI);
    assign in_cv_s  = (width_q >= CV_MIN) && (width_q <= CV_MAX);

    // Next-state logic for the frame FSM, cell phase tracking and word assembly.
    always_comb begin
        state_d    = state_q;
        qcount_d   = qcount_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        perr_d     = perr_q;
        active_d   = active_q;
        strobe_d   = 1'b0;
        error_d    = 1'b0;

        if (accept_s) begin
            phase_d    = PH_HALF;
            mid_seen_d = 1'b1;
        end else if (phase_q == PH_LAST) begin
            phase_d    = '0;
            mid_seen_d = 1'b0;
        end else begin
            phase_d    = phase_q + PW'(1);
            mid_seen_d = mid_seen_q;
        end

        if (edge_s) begin
            width_d = WW'(1);
        end else if (width_q != W_SAT) begin
            width_d = width_q + WW'(1);
        end else begin
            width_d = width_q;
        end

        case (state_q)
            S_IDLE: begin
                // Phase is unknown here: any falling edge is taken as the first 1 bit.
                if (fall_s) begin
                    state_d    = S_QUIESCE;
                    qcount_d   = 3'd1;
                    phase_d    = PH_HALF;
                    mid_seen_d = 1'b1;
                end else if (rise_s) begin
                    phase_d    = '0;
                    mid_seen_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_QUIESCE: begin
                if (accept_s) begin
                    qcount_d = fall_s ? ((qcount_q == 3'd5) ? 3'd5 : qcount_q + 3'd1) : 3'd0;
                end else if (!edge_s && (width_q > CV_MIN)) begin
                    state_d = (sync2_q && (qcount_q >= 3'd5)) ? S_CV_HIGH : S_IDLE;
                end else begin
                    state_d = S_QUIESCE;
                end
            end
            S_CV_HIGH: begin
                if (fall_s) begin
                    state_d = in_cv_s ? S_CV_LOW : S_IDLE;
                end else if (width_q > CV_MAX) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CV_HIGH;
                end
            end
            S_CV_LOW: begin
                if (rise_s && in_cv_s) begin
                    state_d    = S_SYNC;
                    phase_d    = '0;
                    mid_seen_d = 1'b0;
                    active_d   = 1'b1;
                end else if (rise_s || (width_q > CV_MAX)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CV_LOW;
                end
            end
            S_SYNC, S_DATA, S_PARITY: begin
                if (accept_s) begin
                    case (state_q)
                        S_SYNC: begin
                            if (fall_s) begin
                                state_d  = S_DATA;
                                bitcnt_d = 4'd0;
                            end else begin
                                state_d  = S_IDLE;
                                active_d = 1'b0;
                            end
                        end
                        S_DATA: begin
                            shift_d = {shift_q[8:0], fall_s};
                            if (bitcnt_q == 4'd9) begin
                                state_d = S_PARITY;
                            end else begin
                                bitcnt_d = bitcnt_q + 4'd1;
                            end
                        end
                        S_PARITY: begin
                            data_d   = shift_q;
                            perr_d   = parity_mismatch(shift_q, fall_s);
                            strobe_d = 1'b1;
                            state_d  = S_SYNC;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end else if ((phase_q == PH_TMO) && !mid_seen_q) begin
                    error_d  = 1'b1;
                    active_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, synchronizer and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            state_q    <= S_IDLE;
            phase_q    <= '0;
            mid_seen_q <= 1'b0;
            width_q    <= '0;
            qcount_q   <= 3'd0;
            bitcnt_q   <= 4'd0;
            shift_q    <= 10'd0;
            data_q     <= 10'd0;
            perr_q     <= 1'b0;
            strobe_q   <= 1'b0;
            error_q    <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            sync1_q    <= rx;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            state_q    <= state_d;
            phase_q    <= phase_d;
            mid_seen_q <= mid_seen_d;
            width_q    <= width_d;
            qcount_q   <= qcount_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            strobe_q   <= strobe_d;
            error_q    <= error_d;
            active_q   <= active_d;
        end
    end

    assign active       = active_q;
    assign data         = data_q;
    assign strobe       = strobe_q;
    assign parity_error = perr_q;
    assign error        = error_q;
endmodule

// File: tb/tb_coax_rx.sv
// Directed and randomized frames for coax_rx, checked against a word-level expected list.
module tb_coax_rx;
    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       active, strobe, parity_error, error;
    logic [9:0] data;

    coax_rx #(.CLOCKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .rx(rx), .active(active), .data(data),
        .strobe(strobe), .parity_error(parity_error), .error(error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [10:0] got_mem [0:255];
    int   got_n    = 0;
    int   err_cnt  = 0;
    int   act_cnt  = 0;
    int   both_cnt = 0;
    int   err_long = 0;
    logic prev_err = 1'b0;

    // Records every strobed word and error activity.
    always @(negedge clk) begin
        if (strobe && got_n < 256) begin
            got_mem[got_n] <= {parity_error, data};
            got_n          <= got_n + 1;
        end
        if (error) err_cnt <= err_cnt + 1;
        if (active) act_cnt <= act_cnt + 1;
        if (strobe && error) both_cnt <= both_cnt + 1;
        if (error && prev_err) err_long <= err_long + 1;
        prev_err <= error;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a word is reported with parity_error when data plus parity has odd weight.
    function automatic logic [10:0] expect_word(input logic [9:0] w, input logic p);
        int ones = 0;
        for (int i = 0; i < 10; i++) ones += int'(w[i]);
        ones += int'(p);
        return {logic'(ones % 2), w};
    endfunction

    task automatic hold(input logic lvl, input int n);
        rx = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            hold(1'b1, CPB / 2);
            hold(1'b0, CPB / 2);
        end else begin
            hold(1'b0, CPB / 2);
            hold(1'b1, CPB / 2);
        end
    endtask

    task automatic quiesce(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_cv();
        hold(1'b1, 3 * CPB / 2);
        hold(1'b0, 3 * CPB / 2);
    endtask

    task automatic send_word(input logic [9:0] w, input logic p);
        send_bit(1'b1);
        for (int i = 9; i >= 0; i--) send_bit(w[i]);
        send_bit(p);
    endtask

    logic [9:0] fw [0:3];
    logic       fp [0:3];
    int         fn;

    task automatic do_frame(input string tag);
        int base;
        int e0;
        base = got_n;
        e0   = err_cnt;
        quiesce(5);
        send_cv();
        for (int i = 0; i < fn; i++) begin
            send_word(fw[i], fp[i]);
            if (i == 0) check({tag, "_active"}, 32'(active), 32'd1);
        end
        send_bit(1'b0);
        repeat (3) @(negedge clk);
        check({tag, "_active_end"}, 32'(active), 32'd0);
        hold(1'b0, 4 * CPB);
        check({tag, "_nstrobe"}, 32'(got_n - base), 32'(fn));
        for (int i = 0; i < fn; i++)
            check({tag, "_word"}, 32'(got_mem[base + i]), 32'(expect_word(fw[i], fp[i])));
        check({tag, "_noerr"}, 32'(err_cnt - e0), 32'd0);
    endtask

    initial begin
        int base;
        int e0;
        int a0;

        reset = 1'b1;
        rx    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_active", 32'(active), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_strobe", 32'(strobe), 32'd0);
        check("rst_perr", 32'(parity_error), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("idle_nostrobe", 32'(got_n), 32'd0);
        check("idle_noactive", 32'(act_cnt), 32'd0);
        check("idle_noerror", 32'(err_cnt), 32'd0);

        fn = 1; fw[0] = 10'b0101110101; fp[0] = 1'b0;
        do_frame("one_word");
        check("data_held", 32'(data), 32'(10'b0101110101));

        fn = 2; fw[1] = 10'b1010001110; fp[1] = 1'b1;
        do_frame("two_words");

        fp[0] = 1'b1;
        do_frame("bad_parity");
        fp[0] = 1'b0;

        base = got_n;
        e0   = err_cnt;
        quiesce(5);
        send_cv();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("stall_active_before", 32'(active), 32'd1);
        hold(1'b1, 2 * CPB);
        check("stall_active_after", 32'(active), 32'd0);
        hold(1'b0, 4 * CPB);
        check("stall_error_pulses", 32'(err_cnt - e0), 32'd1);
        check("stall_nostrobe", 32'(got_n - base), 32'd0);
        check("stall_error_width", 32'(err_long), 32'd0);
        fn = 1; fw[0] = 10'b1010001110; fp[0] = 1'b1;
        do_frame("after_stall");

        base = got_n;
        a0   = act_cnt;
        quiesce(3);
        send_cv();
        send_word(10'b0101110101, 1'b0);
        send_bit(1'b0);
        hold(1'b0, 4 * CPB);
        check("short_q_noactive", 32'(act_cnt - a0), 32'd0);
        check("short_q_nostrobe", 32'(got_n - base), 32'd0);

        quiesce(5);
        send_cv();
        send_bit(1'b1);
        for (int i = 9; i >= 5; i--) send_bit(fw[0][i]);
        check("midrst_active_before", 32'(active), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_active", 32'(active), 32'd0);
        check("midrst_data", 32'(data), 32'd0);
        check("midrst_strobe", 32'(strobe), 32'd0);
        check("midrst_perr", 32'(parity_error), 32'd0);
        check("midrst_error", 32'(error), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base  = got_n;
        a0    = act_cnt;
        for (int i = 4; i >= 0; i--) send_bit(fw[0][i]);
        send_bit(fp[0]);
        send_word(10'b0101110101, 1'b0);
        send_bit(1'b0);
        hold(1'b0, 4 * CPB);
        check("postrst_nostrobe", 32'(got_n - base), 32'd0);
        check("postrst_noactive", 32'(act_cnt - a0), 32'd0);
        fn = 1; fw[0] = 10'b0101110101; fp[0] = 1'b0;
        do_frame("postrst_frame");

        for (int f = 0; f < 8; f++) begin
            fn = int'($urandom_range(1, 3));
            for (int i = 0; i < fn; i++) begin
                fw[i] = 10'($urandom);
                fp[i] = (^fw[i]) ^ ($urandom_range(0, 3) == 0);
            end
            hold(1'b0, int'($urandom_range(32, 80)));
            do_frame("random");
        end

        check("strobe_error_overlap", 32'(both_cnt), 32'd0);
        check("error_single_cycle", 32'(err_long), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
